// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray-code counter.
interface gray_counter_if #(
  parameter int CBITS = 9
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [CBITS-1:0] load_val;
  logic [CBITS-1:0] bin_q;
  logic [CBITS-1:0] gray_q;
  logic             zero;
  logic             wrap;
  logic             done;
  logic             hd_err;

  modport master (
    output en, up, clr, load, load_val,
    input  bin_q, gray_q, zero, wrap, done, hd_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output bin_q, gray_q, zero, wrap, done, hd_err
  );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Up/down Gray counter with binary shadow, load/clear, wrap or one-shot terminal
// mode and a Hamming-distance check on every count step.
module gray_counter_ctrl #(
  parameter int CBITS   = 9,
  parameter bit ONESHOT = 1'b0,
  parameter bit DOWN_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  gray_counter_if.slave  bus
);

  if (CBITS < 2 || CBITS > 32) begin : g_bad_cbits
    $error("gray_counter_ctrl: CBITS must be within 2..32");
  end

  localparam logic [CBITS-1:0] ZERO_C = {CBITS{1'b0}};
  localparam logic [CBITS-1:0] ONES_C = {CBITS{1'b1}};
  localparam logic [CBITS-1:0] ONE_C  = {{(CBITS-1){1'b0}}, 1'b1};

  function automatic logic [CBITS-1:0] bin2gray(input logic [CBITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcnt(input logic [CBITS-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < CBITS; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  logic [CBITS-1:0] bin_r;
  logic [CBITS-1:0] gray_r;
  logic             wrap_r;
  logic             done_r;
  logic             hd_err_r;

  logic             up_eff_s;
  logic             at_term_s;
  logic [CBITS-1:0] next_s;
  logic [CBITS-1:0] next_gray_s;

  // Next-step value and terminal detection for the effective direction
  always_comb begin
    up_eff_s    = DOWN_EN ? bus.up : 1'b1;
    at_term_s   = 1'b0;
    next_s      = bin_r;
    if (up_eff_s) begin
      at_term_s = (bin_r == ONES_C);
      next_s    = bin_r + ONE_C;
    end else begin
      at_term_s = (bin_r == ZERO_C);
      next_s    = bin_r - ONE_C;
    end
    next_gray_s = bin2gray(next_s);
  end

  // Counter state, Gray register and status pulses; clr > load > step > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_r    <= ZERO_C;
      gray_r   <= ZERO_C;
      wrap_r   <= 1'b0;
      done_r   <= 1'b0;
      hd_err_r <= 1'b0;
    end else if (bus.clr) begin
      bin_r    <= ZERO_C;
      gray_r   <= ZERO_C;
      wrap_r   <= 1'b0;
      done_r   <= 1'b0;
      hd_err_r <= 1'b0;
    end else if (bus.load) begin
      bin_r    <= bus.load_val;
      gray_r   <= bin2gray(bus.load_val);
      wrap_r   <= 1'b0;
      done_r   <= 1'b0;
      hd_err_r <= 1'b0;
    end else if (bus.en) begin
      if (ONESHOT && at_term_s) begin
        // Terminal reached: hold and latch done instead of wrapping
        wrap_r   <= 1'b0;
        done_r   <= 1'b1;
        hd_err_r <= 1'b0;
      end else begin
        bin_r    <= next_s;
        gray_r   <= next_gray_s;
        wrap_r   <= !ONESHOT && at_term_s;
        hd_err_r <= (popcnt(gray_r ^ next_gray_s) != 6'd1);
      end
    end else begin
      wrap_r   <= 1'b0;
      hd_err_r <= 1'b0;
    end
  end

  assign bus.bin_q  = bin_r;
  assign bus.gray_q = gray_r;
  assign bus.zero   = (bin_r == ZERO_C) & ~rst;
  assign bus.wrap   = wrap_r;
  assign bus.done   = ONESHOT ? done_r : 1'b0;
  assign bus.hd_err = hd_err_r;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed bench for gray_counter_ctrl: wrap, one-shot and up-only builds.
module tb_gray_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.CBITS(4)) ia ();
  gray_counter_if #(.CBITS(3)) ib ();
  gray_counter_if #(.CBITS(2)) ic ();

  gray_counter_ctrl #(.CBITS(4), .ONESHOT(1'b0), .DOWN_EN(1'b1)) ua (.clk(clk), .rst(rst), .bus(ia));
  gray_counter_ctrl #(.CBITS(3), .ONESHOT(1'b1), .DOWN_EN(1'b1)) ub (.clk(clk), .rst(rst), .bus(ib));
  gray_counter_ctrl #(.CBITS(2), .ONESHOT(1'b0), .DOWN_EN(1'b0)) uc (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic       en, up, clr, load;
    logic [3:0] lv;
    logic [3:0] eb, eg;
    logic       ew, ez;
  } vec_t;

  vec_t tbl[32];
  int   n_rows;

  function automatic vec_t mk(logic en, logic up, logic clr, logic load, logic [3:0] lv,
                              logic [3:0] eb, logic [3:0] eg, logic ew, logic ez);
    vec_t v;
    v.en = en; v.up = up; v.clr = clr; v.load = load; v.lv = lv;
    v.eb = eb; v.eg = eg; v.ew = ew; v.ez = ez;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] mb;
    logic       rup;
    logic       ewrap;
    int         seen;

    ia.en = 1'b0; ia.up = 1'b0; ia.clr = 1'b0; ia.load = 1'b0; ia.load_val = 4'd0;
    ib.en = 1'b0; ib.up = 1'b0; ib.clr = 1'b0; ib.load = 1'b0; ib.load_val = 3'd0;
    ic.en = 1'b0; ic.up = 1'b0; ic.clr = 1'b0; ic.load = 1'b0; ic.load_val = 2'd0;

    n_rows = 0;
    // Free-run 17 up steps from reset
    tbl[n_rows++] = mk(1,1,0,0,0,  1, 1,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  2, 3,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  3, 2,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  4, 6,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  5, 7,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  6, 5,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  7, 4,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  8,12,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  9,13,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 10,15,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 11,14,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 12,10,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 13,11,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 14, 9,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0, 15, 8,0,0);
    tbl[n_rows++] = mk(1,1,0,0,0,  0, 0,1,1);
    tbl[n_rows++] = mk(1,1,0,0,0,  1, 1,0,0);
    // Load beats en; then down wrap, holds with up toggling
    tbl[n_rows++] = mk(1,0,0,1,0,  0, 0,0,1);
    tbl[n_rows++] = mk(1,0,0,0,0, 15, 8,1,0);
    tbl[n_rows++] = mk(0,1,0,0,0, 15, 8,0,0);
    tbl[n_rows++] = mk(0,0,0,0,0, 15, 8,0,0);
    tbl[n_rows++] = mk(1,0,0,0,0, 14, 9,0,0);
    // clr beats load and en
    tbl[n_rows++] = mk(1,1,1,1,5,  0, 0,0,1);
    tbl[n_rows++] = mk(0,0,0,1,5,  5, 7,0,0);
    tbl[n_rows++] = mk(0,0,1,0,0,  0, 0,0,1);
    // Loading across the wrap boundary raises no wrap
    tbl[n_rows++] = mk(0,0,0,1,15,15, 8,0,0);
    tbl[n_rows++] = mk(0,0,0,1,0,  0, 0,0,1);
    tbl[n_rows++] = mk(1,0,0,1,15,15, 8,0,0);
    tbl[n_rows++] = mk(1,1,1,0,0,  0, 0,0,1);

    #2;
    chk("rst_bin", 32'(ia.bin_q), 32'd0);
    chk("rst_zero_in_rst", 32'(ia.zero), 32'd0);
    chk("rst_wrap", 32'(ia.wrap), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_zero_after", 32'(ia.zero), 32'd1);
    chk("rst_done_b", 32'(ib.done), 32'd0);

    for (int i = 0; i < n_rows; i++) begin
      ia.en = tbl[i].en; ia.up = tbl[i].up; ia.clr = tbl[i].clr;
      ia.load = tbl[i].load; ia.load_val = tbl[i].lv;
      tick();
      chk($sformatf("tbl%0d_bin", i),  32'(ia.bin_q),  32'(tbl[i].eb));
      chk($sformatf("tbl%0d_gray", i), 32'(ia.gray_q), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_wrap", i), 32'(ia.wrap),   32'(tbl[i].ew));
      chk($sformatf("tbl%0d_zero", i), 32'(ia.zero),   32'(tbl[i].ez));
      chk($sformatf("tbl%0d_hd", i),   32'(ia.hd_err), 32'd0);
      chk($sformatf("tbl%0d_done", i), 32'(ia.done),   32'd0);
    end

    // Async reset between edges while counting at 9
    ia.clr = 1'b0; ia.en = 1'b0; ia.load = 1'b1; ia.load_val = 4'd8;
    tick();
    ia.load = 1'b0; ia.en = 1'b1; ia.up = 1'b1;
    tick();
    chk("mid_bin9", 32'(ia.bin_q), 32'd9);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_bin", 32'(ia.bin_q), 32'd0);
    chk("mid_rst_gray", 32'(ia.gray_q), 32'd0);
    chk("mid_rst_zero", 32'(ia.zero), 32'd0);
    tick();
    chk("mid_rst_hold", 32'(ia.bin_q), 32'd0);
    rst = 1'b0; ia.en = 1'b0;
    #1;
    chk("mid_rel_zero", 32'(ia.zero), 32'd1);
    ia.en = 1'b1;
    tick();
    chk("mid_resume", 32'(ia.bin_q), 32'd1);
    ia.en = 1'b0;

    // One-shot CBITS=3: sticks at 7, done from the 8th edge
    ib.en = 1'b1; ib.up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("os%0d_bin", k),  32'(ib.bin_q), (k < 7) ? 32'(k) : 32'd7);
      chk($sformatf("os%0d_done", k), 32'(ib.done),  (k >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("os%0d_wrap", k), 32'(ib.wrap),  32'd0);
      chk($sformatf("os%0d_hd", k),   32'(ib.hd_err), 32'd0);
    end
    ib.up = 1'b0;
    tick();
    chk("os_rev_bin", 32'(ib.bin_q), 32'd6);
    chk("os_rev_done", 32'(ib.done), 32'd1);
    ib.en = 1'b0; ib.load = 1'b1; ib.load_val = 3'd2;
    tick();
    chk("os_load_bin", 32'(ib.bin_q), 32'd2);
    chk("os_load_done", 32'(ib.done), 32'd0);
    ib.load_val = 3'd0;
    tick();
    ib.load = 1'b0; ib.en = 1'b1;
    tick();
    chk("os_dn_bin", 32'(ib.bin_q), 32'd0);
    chk("os_dn_done", 32'(ib.done), 32'd1);
    chk("os_dn_wrap", 32'(ib.wrap), 32'd0);
    ib.en = 1'b0; ib.clr = 1'b1;
    tick();
    chk("os_clr_done", 32'(ib.done), 32'd0);
    ib.clr = 1'b0;

    // Up-only build ignores up=0
    ic.en = 1'b1; ic.up = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("uo%0d_bin", k),  32'(ic.bin_q), 32'(k % 4));
      chk($sformatf("uo%0d_wrap", k), 32'(ic.wrap), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("uo_gray", 32'(ic.gray_q), 32'd1);
    ic.en = 1'b0;

    // Random up/down steps against a binary model
    ia.en = 1'b0; ia.load = 1'b1; ia.load_val = 4'd3;
    tick();
    mb = 4'd3;
    ia.load = 1'b0; ia.en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      rup = 1'($urandom_range(0, 1));
      ia.up = rup;
      ewrap = rup ? (mb == 4'd15) : (mb == 4'd0);
      mb = rup ? mb + 4'd1 : mb - 4'd1;
      tick();
      chk($sformatf("rnd%0d_bin", k),  32'(ia.bin_q),  32'(mb));
      chk($sformatf("rnd%0d_gray", k), 32'(ia.gray_q), 32'(mb ^ (mb >> 1)));
      chk($sformatf("rnd%0d_wrap", k), 32'(ia.wrap),   32'(ewrap));
      chk($sformatf("rnd%0d_hd", k),   32'(ia.hd_err), 32'd0);
    end

    // Zero recurs exactly once per 16 free-run steps
    ia.up = 1'b1;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (ia.zero) seen++;
    end
    chk("liveness_zero", 32'(seen), 32'd1);
    ia.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
